topk_sorter: RTL

//  Streaming top-K selector: accepts one (dist, pointa, pointb) tuple per cycle.

---
 rtl/topk_sorter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/topk_sorter.sv
// Streaming top-K selector: parallel-insertion sorted register list, drained best-first per batch.
// Optional TOPK_DROP_CNT_EN adds a saturating per-batch count of discarded tuples (drop_cnt).
module topk_sorter #(
   parameter int NUM_POINTS = 1000,
   parameter int DEPTH      = 1000,
   parameter int DIST_W     = 40,
   parameter int SORT_OP    = 0,
   localparam int PW        = $clog2(NUM_POINTS),
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIST_W-1:0] in_dist,
   input  logic [PW-1:0]     in_pointa,
   input  logic [PW-1:0]     in_pointb,
   input  logic              in_vld,
   input  logic              in_last,
   output logic              in_rdy,
   output logic [PW-1:0]     out_pointa,
   output logic [PW-1:0]     out_pointb,
   output logic [DIST_W-1:0] out_dist,
   output logic              out_vld,
   output logic              out_last,
   input  logic              out_rdy,
   output logic [CW-1:0]     fill_cnt,
   output logic              batch_done
`ifdef TOPK_DROP_CNT_EN
   ,output logic [31:0]      drop_cnt
`endif
);

   typedef enum logic {S_FILL, S_DRAIN} state_t;

   state_t              r_state;
   logic [DEPTH-1:0]    r_vld;
   logic [CW-1:0]       r_fill;
   logic                r_done;
   logic [DIST_W-1:0]   r_dist [DEPTH];
   logic [PW-1:0]       r_pa   [DEPTH];
   logic [PW-1:0]       r_pb   [DEPTH];
`ifdef TOPK_DROP_CNT_EN
   logic [31:0]         r_drop;
`endif

   logic [DEPTH-1:0]    w_beat;
   logic [DEPTH-1:0]    w_prev_beat;
   logic [DIST_W-1:0]   w_dn_dist [DEPTH];
   logic [PW-1:0]       w_dn_pa   [DEPTH];
   logic [PW-1:0]       w_dn_pb   [DEPTH];
   logic [DIST_W-1:0]   w_up_dist [DEPTH];
   logic [PW-1:0]       w_up_pa   [DEPTH];
   logic [PW-1:0]       w_up_pb   [DEPTH];
   logic                w_accept;
   logic                w_pop;

   assign w_accept = (r_state == S_FILL) && in_vld;
   assign w_pop    = out_vld && out_rdy;

   // Beats form a prefix of the sorted list, so the first non-beating slot is the insert point.
   assign w_prev_beat = {w_beat[DEPTH-2:0], 1'b1};

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         if (SORT_OP == 0) begin : g_min
            assign w_beat[gi] = r_vld[gi] && (r_dist[gi] <= in_dist);
         end else begin : g_max
            assign w_beat[gi] = r_vld[gi] && (r_dist[gi] >= in_dist);
         end

         if (gi == 0) begin : g_head
            assign w_dn_dist[gi] = in_dist;
            assign w_dn_pa[gi]   = in_pointa;
            assign w_dn_pb[gi]   = in_pointb;
         end else begin : g_body
            assign w_dn_dist[gi] = r_dist[gi-1];
            assign w_dn_pa[gi]   = r_pa[gi-1];
            assign w_dn_pb[gi]   = r_pb[gi-1];
         end

         if (gi == DEPTH - 1) begin : g_tail
            assign w_up_dist[gi] = r_dist[gi];
            assign w_up_pa[gi]   = r_pa[gi];
            assign w_up_pb[gi]   = r_pb[gi];
         end else begin : g_inner
            assign w_up_dist[gi] = r_dist[gi+1];
            assign w_up_pa[gi]   = r_pa[gi+1];
            assign w_up_pb[gi]   = r_pb[gi+1];
         end
      end
   endgenerate

   // Payload needs no reset: every slot is qualified by its r_vld bit.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_accept && !w_beat[i]) begin
            if (w_prev_beat[i]) begin
               r_dist[i] <= in_dist;
               r_pa[i]   <= in_pointa;
               r_pb[i]   <= in_pointb;
            end else begin
               r_dist[i] <= w_dn_dist[i];
               r_pa[i]   <= w_dn_pa[i];
               r_pb[i]   <= w_dn_pb[i];
            end
         end else if (w_pop) begin
            r_dist[i] <= w_up_dist[i];
            r_pa[i]   <= w_up_pa[i];
            r_pb[i]   <= w_up_pb[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FILL;
         r_vld   <= '0;
         r_fill  <= '0;
         r_done  <= 1'b0;
`ifdef TOPK_DROP_CNT_EN
         r_drop  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_FILL: begin
               if (w_accept && !w_beat[DEPTH-1]) begin
                  r_vld <= {r_vld[DEPTH-2:0], 1'b1};
                  if (!r_vld[DEPTH-1]) begin
                     r_fill <= r_fill + CW'(1);
                  end
               end
`ifdef TOPK_DROP_CNT_EN
               // A full list always loses one tuple: either the input or the evicted tail.
               if (w_accept && r_vld[DEPTH-1] && (r_drop != 32'hFFFF_FFFF)) begin
                  r_drop <= r_drop + 32'd1;
               end
`endif
               if (in_last) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!r_vld[0] || (w_pop && !r_vld[1])) begin
                  r_state <= S_FILL;
                  r_vld   <= '0;
                  r_fill  <= '0;
                  r_done  <= 1'b1;
`ifdef TOPK_DROP_CNT_EN
                  r_drop  <= '0;
`endif
               end else if (w_pop) begin
                  r_vld  <= {1'b0, r_vld[DEPTH-1:1]};
                  r_fill <= r_fill - CW'(1);
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

   assign in_rdy     = (r_state == S_FILL);
   assign out_vld    = (r_state == S_DRAIN) && r_vld[0];
   assign out_last   = out_vld && !r_vld[1];
   assign out_dist   = r_dist[0];
   assign out_pointa = r_pa[0];
   assign out_pointb = r_pb[0];
   assign fill_cnt   = r_fill;
   assign batch_done = r_done;
`ifdef TOPK_DROP_CNT_EN
   assign drop_cnt   = r_drop;
`endif

endmodule
